// File: rtl/bcd_entry_pkg.sv
// bcd_entry_pkg: shared state encoding, digit limit and result-width helper for BCD entry
package bcd_entry_pkg;
  typedef enum logic [1:0] {COLLECT, CONVERT, HOLD} state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  function automatic int min_bin_w(input int num_digits);
    int max_val = 1;
    int w = 0;
    for (int i = 0; i < num_digits; i++) max_val = max_val * 10;
    while ((1 << w) <= max_val - 1) w++;
    return w;
  endfunction
endpackage

// File: rtl/key_press_detect.sv
// key_press_detect: synchronizes an active-low push-button and emits one pulse per press
module key_press_detect (
  input  logic clock,
  input  logic resetn,
  input  logic key_n,
  output logic press
);
  logic s1, s2, s3;
  // two sync flops plus a history flop, preset to "released" so reset never fakes a press
  always_ff @(posedge clock)
    if (!resetn) {s1, s2, s3} <= 3'b111;
    else {s1, s2, s3} <= {key_n, s1, s2};
  assign press = s3 & ~s2;
endmodule

// File: rtl/bcd_digit_entry.sv
// bcd_digit_entry: collects MSD-first BCD key entries and converts them to binary with a valid/ready output
module bcd_digit_entry
  import bcd_entry_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int BIN_W      = 7
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [3:0]       digit_in,
  input  logic             strobe_n,
  input  logic             clear,
  output logic [BIN_W-1:0] bin_out,
  output logic             bin_valid,
  input  logic             bin_ready,
  output logic [1:0]       digit_count,
  output logic             busy,
  output logic             error
);
  localparam logic [1:0] LAST = 2'(NUM_DIGITS - 1);
  localparam logic [1:0] NDIG = 2'(NUM_DIGITS);
  if (NUM_DIGITS < 1 || NUM_DIGITS > 3) begin : g_bad_digits
    $error("NUM_DIGITS must be 1..3");
  end
  if (BIN_W < min_bin_w(NUM_DIGITS)) begin : g_bad_width
    $error("BIN_W too narrow for NUM_DIGITS");
  end
  state_t state, state_next;
  logic press, accept, reject;
  logic [3:0] digits [4];
  logic [1:0] count, idx;
  logic [BIN_W-1:0] acc;
  logic [BIN_W+3:0] acc_wide, acc_sum;
  key_press_detect u_key (
    .clock (clock),
    .resetn(resetn),
    .key_n (strobe_n),
    .press (press)
  );
  assign accept      = (state == COLLECT) && press && (digit_in <= BCD_MAX);
  assign reject      = (state == COLLECT) && press && (digit_in > BCD_MAX);
  assign busy        = (state != COLLECT);
  assign digit_count = count;
  // state register
  always_ff @(posedge clock)
    if (!resetn) state <= COLLECT;
    else state <= state_next;
  // next state and the acc*10 + digit step, done as shifts at widened precision
  always_comb begin
    state_next = state;
    acc_wide   = {4'b0, acc};
    acc_sum    = (acc_wide << 3) + (acc_wide << 1) + {{BIN_W{1'b0}}, digits[idx]};
    state_next = clear              ? COLLECT :
                 state == COLLECT   ? ((accept && count == LAST) ? CONVERT : COLLECT) :
                 state == CONVERT   ? ((idx == NDIG) ? HOLD : CONVERT) :
                 state == HOLD      ? ((bin_valid && bin_ready) ? COLLECT : HOLD) :
                 COLLECT;
  end
  // digit buffer, accumulator, result register and sticky error
  always_ff @(posedge clock)
    if (!resetn) begin
      for (int i = 0; i < 4; i++) digits[i] <= 4'd0;
      count     <= 2'd0;
      idx       <= 2'd0;
      acc       <= '0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      error     <= 1'b0;
    end else if (clear) begin
      count     <= 2'd0;
      bin_valid <= 1'b0;
      error     <= 1'b0;
    end else if (state == COLLECT) begin
      if (accept) begin
        digits[count] <= digit_in;
        count         <= count + 2'd1;
        acc           <= '0;
        idx           <= 2'd0;
      end
      if (reject) error <= 1'b1;
    end else if (state == CONVERT) begin
      if (idx == NDIG) begin
        bin_out   <= acc;
        bin_valid <= 1'b1;
      end else begin
        acc <= acc_sum[BIN_W-1:0];
        idx <= idx + 2'd1;
      end
    end else if (state == HOLD && bin_valid && bin_ready) begin
      bin_valid <= 1'b0;
      count     <= 2'd0;
    end
endmodule

// File: tb/tb_bcd_digit_entry.sv
// tb_bcd_digit_entry: directed and randomized checks of BCD key entry against a decimal model
module tb_bcd_digit_entry;
  localparam int ND = 2;
  localparam int BW = 7;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic strobe_n = 1'b1;
  logic clear = 1'b0;
  logic bin_ready = 1'b1;
  logic [3:0] digit_in = 4'd0;
  logic [BW-1:0] bin_out;
  logic bin_valid, busy, error;
  logic [1:0] digit_count;
  int checks = 0;
  int errors = 0;
  int q[$];
  bit m_err = 1'b0;
  int expv;
  logic [3:0] d;
  bit keep;
  int n;

  bcd_digit_entry #(.NUM_DIGITS(ND), .BIN_W(BW)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .digit_in   (digit_in),
    .strobe_n   (strobe_n),
    .clear      (clear),
    .bin_out    (bin_out),
    .bin_valid  (bin_valid),
    .bin_ready  (bin_ready),
    .digit_count(digit_count),
    .busy       (busy),
    .error      (error)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clock);
  endtask

  task automatic key(input logic [3:0] dv, input int hold);
    digit_in = dv;
    strobe_n = 1'b0;
    tick(hold);
    strobe_n = 1'b1;
    tick(3);
  endtask

  function automatic int model_value();
    int v = 0;
    for (int i = 0; i < q.size(); i++) v += q[i] * (10 ** (q.size() - 1 - i));
    return v;
  endfunction

  task automatic enter(input logic [3:0] dv);
    key(dv, 3);
    if (dv > 4'd9) m_err = 1'b1;
    else q.push_back(int'(dv));
    check("entry_error", error, m_err);
    check("entry_count", digit_count, q.size());
  endtask

  task automatic finish(input logic [3:0] dv, input bit hold_result, output int ev);
    int lat = 0;
    q.push_back(int'(dv));
    ev = model_value();
    q.delete();
    bin_ready = !hold_result;
    digit_in = dv;
    strobe_n = 1'b0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clock);
      if (i == 3) strobe_n = 1'b1;
      if (bin_valid) lat = i;
    end
    strobe_n = 1'b1;
    check("latency", lat, 3 + ND + 1);
    check("result", bin_out, ev);
    check("busy_hold", busy, 1);
    check("count_hold", digit_count, ND);
    check("error_hold", error, m_err);
    if (!hold_result) begin
      tick(1);
      check("valid_pulse", bin_valid, 0);
      check("count_after", digit_count, 0);
      check("busy_after", busy, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out"}, bin_out, 0);
    check({tag, "_valid"}, bin_valid, 0);
    check({tag, "_count"}, digit_count, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_error"}, error, 0);
  endtask

  initial begin
    tick(2);
    check_all_zero("reset");
    resetn = 1'b1;
    tick(2);

    enter(4'd4);
    finish(4'd7, 1'b0, expv);
    check("value_47", expv, 47);

    enter(4'd9);
    finish(4'd9, 1'b0, expv);
    enter(4'd0);
    finish(4'd0, 1'b0, expv);
    check("no_error", error, 0);

    enter(4'd12);
    enter(4'd3);
    finish(4'd5, 1'b0, expv);
    check("error_sticky", error, 1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    m_err = 1'b0;
    check("error_cleared", error, 0);

    enter(4'd8);
    finish(4'd2, 1'b1, expv);
    key(4'd5, 3);
    check("hold_valid_a", bin_valid, 1);
    check("hold_out_a", bin_out, 82);
    key(4'd13, 3);
    check("hold_valid_b", bin_valid, 1);
    check("hold_error_b", error, 0);
    key(4'd1, 3);
    check("hold_out_c", bin_out, 82);
    check("hold_count_c", digit_count, ND);
    bin_ready = 1'b1;
    tick(1);
    check("release_valid", bin_valid, 0);
    check("release_count", digit_count, 0);
    check("release_busy", busy, 0);

    key(4'd3, 50);
    check("held_one_digit", digit_count, 1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clear_count", digit_count, 0);
    tick(8);
    check("clear_no_result", bin_valid, 0);
    check("clear_idle", busy, 0);

    enter(4'd1);
    digit_in = 4'd2;
    strobe_n = 1'b0;
    tick(3);
    check("busy_convert", busy, 1);
    strobe_n = 1'b1;
    resetn = 1'b0;
    tick(1);
    check_all_zero("reset_convert");
    resetn = 1'b1;
    q.delete();
    tick(2);

    enter(4'd5);
    finish(4'd5, 1'b1, expv);
    resetn = 1'b0;
    tick(1);
    check_all_zero("reset_hold");
    resetn = 1'b1;
    bin_ready = 1'b1;
    m_err = 1'b0;
    tick(2);

    enter(4'd6);
    finish(4'd1, 1'b0, expv);
    check("value_61", expv, 61);

    for (int e = 0; e < 25; e++) begin
      if (e % 6 == 5) begin
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        m_err = 1'b0;
        check("rand_clear", error, 0);
      end
      while (q.size() < ND - 1) begin
        d = 4'($urandom_range(0, 15));
        enter(d);
      end
      d = 4'($urandom_range(0, 9));
      keep = ($urandom_range(0, 2) == 0);
      finish(d, keep, expv);
      if (keep) begin
        n = $urandom_range(1, 6);
        repeat (n) begin
          tick(1);
          check("rand_hold_valid", bin_valid, 1);
          check("rand_hold_out", bin_out, expv);
        end
        bin_ready = 1'b1;
        tick(1);
        check("rand_release_valid", bin_valid, 0);
        check("rand_release_count", digit_count, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
